// File: rtl/font_rom_arbiter_if.sv
// rtl/font_rom_arbiter_if.sv - requester-side request/grant/response bundle for font_rom_arbiter
interface font_rom_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8,
   parameter int ID_W   = $clog2(N_REQ)
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ-1:0]        gnt;
   logic                    rsp_valid;
   logic [ID_W-1:0]         rsp_id;
   logic [DATA_W-1:0]       rsp_data;

   modport master (
      output req, req_addr,
      input  gnt, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req, req_addr,
      output gnt, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/font_rom_arbiter.sv
// rtl/font_rom_arbiter.sv - shares one synchronous-read font ROM among N_REQ requesters
// FONT_ARB_ROUND_ROBIN_EN selects round-robin arbitration; fixed priority (lowest index) otherwise.
module font_rom_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8,
   parameter int ID_W   = $clog2(N_REQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   font_rom_arbiter_if.slave bus,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data
);
   logic [N_REQ-1:0] gnt_c;
   logic [ID_W-1:0]  gnt_id;
   logic             hit;
   int               idx;

   logic             v1, v2;
   logic [ID_W-1:0]  id1, id2;

`ifdef FONT_ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0]  ptr;
`endif

   always_comb begin
      gnt_c  = '0;
      gnt_id = '0;
      hit    = 1'b0;
      idx    = 0;
      for (int k = 0; k < N_REQ; k++) begin
`ifdef FONT_ARB_ROUND_ROBIN_EN
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
`else
         idx = k;
`endif
         if (!hit && bus.req[idx]) begin
            hit        = 1'b1;
            gnt_c[idx] = 1'b1;
            gnt_id     = ID_W'(idx);
         end
      end
   end

   // Grant is withheld while reset is asserted so nothing is acknowledged and then lost.
   assign bus.gnt = rst_n ? gnt_c : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr      <= '0;
         v1            <= 1'b0;
         v2            <= 1'b0;
         id1           <= '0;
         id2           <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_data  <= '0;
`ifdef FONT_ARB_ROUND_ROBIN_EN
         ptr           <= '0;
`endif
      end else begin
         if (hit) begin
            rom_addr <= bus.req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
`ifdef FONT_ARB_ROUND_ROBIN_EN
            ptr      <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
`endif
         end
         // Stage 1 aligns with rom_addr, stage 2 with the ROM's registered data.
         v1            <= hit;
         id1           <= gnt_id;
         v2            <= v1;
         id2           <= id1;
         bus.rsp_valid <= v2;
         if (v2) begin
            bus.rsp_id   <= id2;
            bus.rsp_data <= rom_data;
         end
      end
   end
endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb/tb_font_rom_arbiter.sv - directed self-checking bench for font_rom_arbiter
module tb_font_rom_arbiter;
   localparam int N_REQ  = 4;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 8;
   localparam int ID_W   = 2;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;

   font_rom_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

   font_rom_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .rom_addr (rom_addr),
      .rom_data (rom_data)
   );

   typedef struct {
      int               cyc;
      int               id;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // req3 | req2 | req1 | req0
   logic [N_REQ*ADDR_W-1:0] av = {11'h3C5, 11'h012, 11'h0A7, 11'h155};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
      if (a == 11'h012) return 8'h7C;
      return a[7:0] ^ 8'hA5 ^ {5'b0, a[10:8]};
   endfunction

   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("rsp_id",    32'(bus.rsp_id),    32'(exp_q[0].id));
         chk("rsp_data",  32'(bus.rsp_data),  32'(exp_q[0].data));
         void'(exp_q.pop_front());
      end else begin
         chk("rsp_quiet", 32'(bus.rsp_valid), 32'd0);
      end
   end

   // Entered at posedge+1; drives one cycle, checks gnt mid-cycle, returns at next posedge+1.
   task automatic cycle_chk(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] eg, input string tag);
      bus.req      = r;
      bus.req_addr = av;
      @(negedge clk);
      chk(tag, 32'(bus.gnt), 32'(eg));
      for (int i = 0; i < N_REQ; i++)
         if (eg[i]) exp_q.push_back('{cyc + 3, i, rom_fn(av[i*ADDR_W +: ADDR_W])});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle_chk('0, '0, "gnt_idle");
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.req      = '0;
      bus.req_addr = av;
      repeat (2) @(posedge clk);
      #1;
      bus.req = 4'b1111;
      @(negedge clk);
      chk("rst_gnt",       32'(bus.gnt),       32'd0);
      chk("rst_rom_addr",  32'(rom_addr),      32'd0);
      chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
      chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Full contention straight out of reset
`ifdef FONT_ARB_ROUND_ROBIN_EN
      cycle_chk(4'b1111, 4'b0001, "cont_g0");
      cycle_chk(4'b1111, 4'b0010, "cont_g1");
      cycle_chk(4'b1111, 4'b0100, "cont_g2");
      cycle_chk(4'b1111, 4'b1000, "cont_g3");
      cycle_chk(4'b1111, 4'b0001, "cont_g4");
      cycle_chk(4'b1111, 4'b0010, "cont_g5");
      cycle_chk(4'b1110, 4'b0100, "drop0");
`else
      for (int i = 0; i < 6; i++) cycle_chk(4'b1111, 4'b0001, "fixed_g0");
      cycle_chk(4'b1110, 4'b0010, "drop0");
`endif
      idle(4);

      // Pointer wrap from requester 3
      cycle_chk(4'b1000, 4'b1000, "wrap_g3");
      cycle_chk(4'b1001, 4'b0001, "wrap_g0");
`ifdef FONT_ARB_ROUND_ROBIN_EN
      cycle_chk(4'b1001, 4'b1000, "wrap_then3");
`else
      cycle_chk(4'b1001, 4'b0001, "wrap_fixed0");
`endif
      idle(4);

      // Single request from requester 2
      cycle_chk(4'b0100, 4'b0100, "single_g2");
      bus.req = '0;
      #2;
      chk("single_rom_addr", 32'(rom_addr), 32'h012);
      idle(4);

      // Reset while two responses are in flight
      cycle_chk(4'b0001, 4'b0001, "mid_g0");
      cycle_chk(4'b0010, 4'b0010, "mid_g1");
      rst_n   = 1'b0;
      bus.req = 4'b1111;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_gnt",      32'(bus.gnt),  32'd0);
      chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle_chk(4'b1111, 4'b0001, "post_rst_g0");
      bus.req = '0;
      idle(6);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
